// File: rtl/audio_pkg.sv
// audio_pkg: shared widths and FSM state / display codes for the audio sequencer
package audio_pkg;
  localparam int DEF_ADDR_W  = 20;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_SPEED_W = 3;
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_REC        = 3'd1;
  localparam logic [2:0] ST_REC_PAUSE  = 3'd2;
  localparam logic [2:0] ST_PLAY       = 3'd3;
  localparam logic [2:0] ST_PLAY_PAUSE = 3'd4;
endpackage

// File: rtl/audio_play_addr_gen.sv
// audio_play_addr_gen: playback pointer with fast skip / slow repeat stepping and end-of-data detect
module audio_play_addr_gen
  import audio_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int SPEED_W = DEF_SPEED_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_step,
  input  logic               i_fast,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic [ADDR_W-1:0]  i_end_addr,
  output logic [ADDR_W-1:0]  o_play_ptr,
  output logic               o_done
);
  localparam int WW = ADDR_W + SPEED_W + 1;
  logic [SPEED_W-1:0] repeat_cnt;
  logic               adv;
  logic [WW-1:0]      step, next_ptr;
  // per-frame step: skip speed+1 when fast, else advance once every speed+1 frames
  always_comb begin
    adv      = i_fast || repeat_cnt >= i_speed;
    step     = !adv ? '0 : i_fast ? WW'(i_speed) + WW'(1) : WW'(1);
    next_ptr = WW'(o_play_ptr) + step;
  end
  // pointer, repeat counter and the wide end-of-data compare, updated once per frame
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      o_play_ptr <= '0;
      repeat_cnt <= '0;
      o_done     <= 1'b0;
    end else if (i_step) begin
      o_play_ptr <= next_ptr[ADDR_W-1:0];
      repeat_cnt <= adv ? '0 : repeat_cnt + SPEED_W'(1);
      o_done     <= next_ptr > WW'(i_end_addr);
    end
  end
endmodule

// File: rtl/audio_sram_sequencer.sv
// audio_sram_sequencer: BCLK-domain FSM time-sharing one SRAM between I2S recording and playback
module audio_sram_sequencer
  import audio_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = '1,
  parameter int                SPEED_W  = DEF_SPEED_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_daclrck,
  input  logic               i_key_rec,
  input  logic               i_key_play,
  input  logic               i_key_pause,
  input  logic               i_key_stop,
  input  logic               i_fast,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic               i_rec_valid,
  input  logic [DATA_W-1:0]  i_rec_data,
  output logic               o_rec_start,
  output logic               o_rec_pause,
  output logic               o_rec_stop,
  output logic               o_play_en,
  output logic [DATA_W-1:0]  o_play_data,
  output logic [ADDR_W-1:0]  o_sram_addr,
  output logic [DATA_W-1:0]  o_sram_wdata,
  output logic               o_sram_we_n,
  input  logic [DATA_W-1:0]  i_sram_rdata,
  output logic [ADDR_W-1:0]  o_end_addr,
  output logic [2:0]         o_state
);
  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] rec_ptr, play_ptr;
  logic              lrck_q, lrck_d, fetch_q, has_rec, play_done;
  logic              frame, fetch, wr_go, auto_stop, k_stop, k_pause, k_rec, k_play;
  assign frame     = lrck_d && !lrck_q && state == ST_PLAY;
  assign fetch     = frame && !play_done;
  assign auto_stop = !o_sram_we_n && o_end_addr == MAX_ADDR && (state == ST_REC || state == ST_REC_PAUSE);
  assign wr_go     = i_rec_valid && state == ST_REC && !auto_stop;
  assign k_stop    = i_key_stop && state != ST_IDLE;
  assign k_pause   = i_key_pause && (state == ST_REC || state == ST_PLAY);
  assign k_rec     = i_key_rec && (state == ST_IDLE || state == ST_REC_PAUSE);
  assign k_play    = i_key_play && ((state == ST_IDLE && has_rec) || state == ST_PLAY_PAUSE);
  assign o_play_en = state == ST_PLAY;
  assign o_state   = state;
  // next state: only legal keys take part, with stop > pause > rec > play
  always_comb
    state_nxt = (k_stop || auto_stop || (frame && play_done)) ? ST_IDLE :
                k_pause ? (state == ST_REC ? ST_REC_PAUSE : ST_PLAY_PAUSE) :
                k_rec   ? ST_REC :
                k_play  ? ST_PLAY : state;
  // FSM, recorder command pulses, SRAM write/fetch mux and playback sample register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      o_rec_start  <= 1'b0;
      o_rec_pause  <= 1'b0;
      o_rec_stop   <= 1'b0;
      o_play_data  <= '0;
      o_sram_addr  <= '0;
      o_sram_wdata <= '0;
      o_sram_we_n  <= 1'b1;
      o_end_addr   <= '0;
      rec_ptr      <= '0;
      has_rec      <= 1'b0;
      lrck_q       <= 1'b0;
      lrck_d       <= 1'b0;
      fetch_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_rec_start <= state_nxt == ST_REC && state != ST_REC;
      o_rec_pause <= state_nxt == ST_REC_PAUSE && state == ST_REC;
      o_rec_stop  <= state_nxt == ST_IDLE && (state == ST_REC || state == ST_REC_PAUSE);
      lrck_q      <= i_daclrck;
      lrck_d      <= lrck_q;
      fetch_q     <= fetch;
      o_sram_we_n <= !wr_go;
      if (wr_go) begin
        o_sram_addr  <= rec_ptr;
        o_sram_wdata <= i_rec_data;
        o_end_addr   <= rec_ptr;
        rec_ptr      <= rec_ptr + ADDR_W'(1);
        has_rec      <= 1'b1;
      end else if (fetch) begin
        o_sram_addr <= play_ptr;
      end
      if (state == ST_IDLE && state_nxt == ST_REC) rec_ptr <= '0;
      if (fetch_q) o_play_data <= i_sram_rdata;
    end
  end
  audio_play_addr_gen #(
    .ADDR_W (ADDR_W),
    .SPEED_W(SPEED_W)
  ) u_addr_gen (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (state == ST_IDLE && state_nxt == ST_PLAY),
    .i_step    (fetch),
    .i_fast    (i_fast),
    .i_speed   (i_speed),
    .i_end_addr(o_end_addr),
    .o_play_ptr(play_ptr),
    .o_done    (play_done)
  );
endmodule
